// File: rtl/mseq_pkg.sv
// rtl/mseq_pkg.sv - shared types, default tap masks and step function for mseq_gen
package mseq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RECOVER = 2'd2
  } mseq_state_e;

  // Bit i set means state bit i feeds the XOR (x^n term maps to bit n-1).
  localparam logic [31:0] TAPS_N4  = 32'h0000_000C;
  localparam logic [31:0] TAPS_N7  = 32'h0000_0060;
  localparam logic [31:0] TAPS_N9  = 32'h0000_0110;
  localparam logic [31:0] TAPS_N11 = 32'h0000_0500;
  localparam logic [31:0] TAPS_N15 = 32'h0000_6000;
  localparam logic [31:0] TAPS_N16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_N23 = 32'h0042_0000;
  localparam logic [31:0] TAPS_N31 = 32'h4800_0000;

  function automatic logic [31:0] default_taps(input int n);
    case (n)
      4:       return TAPS_N4;
      7:       return TAPS_N7;
      9:       return TAPS_N9;
      11:      return TAPS_N11;
      15:      return TAPS_N15;
      16:      return TAPS_N16;
      23:      return TAPS_N23;
      31:      return TAPS_N31;
      default: return 32'h1 << (n - 1);
    endcase
  endfunction

  // Callers zero-extend narrower states, so the parity only sees the live bits.
  function automatic logic [31:0] next_state(input logic [31:0] s, input logic [31:0] taps);
    return {s[30:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/mseq_step.sv
// rtl/mseq_step.sv - one combinational Fibonacci LFSR step
module mseq_step
  import mseq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] s,
  input  logic [N-1:0] taps,
  output logic [N-1:0] s_next,
  output logic         out
);

  assign s_next = N'(next_state(32'(s), 32'(taps)));
  assign out    = s[N-1];

endmodule

// File: rtl/mseq_gen.sv
// rtl/mseq_gen.sv - parametrised m-sequence generator, W bits per enabled cycle
// Optional all-zero state recovery when MSEQ_ZERO_GUARD_EN is defined.
module mseq_gen
  import mseq_pkg::*;
#(
  parameter int           N        = 16,
  parameter int           W        = 1,
  parameter logic [N-1:0] DEF_TAPS = N'(default_taps(N)),
  parameter logic [N-1:0] DEF_SEED = N'(1)
) (
  input  logic         clk_sig,
  input  logic         rst_sig,
  input  logic         en_sig,
  input  logic         load_sig,
  input  logic [N-1:0] seed_sig,
  input  logic [N-1:0] taps_sig,
  output logic         m_sig,
  output logic [W-1:0] m_par_sig,
  output logic         valid_sig,
  output logic         wrap_sig,
  output logic [N-1:0] step_cnt_sig
);

  mseq_state_e  fsm_q, fsm_d;
  logic [N-1:0] lfsr_q, lfsr_d;
  logic [N-1:0] taps_q, taps_d;
  logic [N-1:0] seed_q, seed_d;
  logic [W-1:0] par_q, par_d;
  logic         valid_q, valid_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] cnt_q, cnt_d;

  logic [N-1:0] chain_s [0:W];
  logic [W-1:0] chunk;
  logic [W-1:0] hit;
  logic [N-1:0] steps_past;

  assign chain_s[0] = lfsr_q;

  for (genvar k = 0; k < W; k++) begin : g_chain
    mseq_step #(.N(N)) u_step (
      .s      (chain_s[k]),
      .taps   (taps_q),
      .s_next (chain_s[k+1]),
      .out    (chunk[W-1-k])
    );
    assign hit[k] = (chain_s[k+1] == seed_q);
  end

  // The latest seed match in the chunk decides how many steps are already past the wrap.
  always_comb begin
    steps_past = '0;
    for (int k = 0; k < W; k++) begin
      if (hit[k]) steps_past = N'(W - 1 - k);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    lfsr_d  = lfsr_q;
    taps_d  = taps_q;
    seed_d  = seed_q;
    par_d   = par_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    case (fsm_q)
      S_IDLE, S_RUN: begin
        if (load_sig) begin
          lfsr_d = seed_sig;
          taps_d = taps_sig;
          seed_d = seed_sig;
          cnt_d  = '0;
          fsm_d  = S_RUN;
`ifdef MSEQ_ZERO_GUARD_EN
          if (seed_sig == '0) fsm_d = S_RECOVER;
`endif
        end else if (en_sig) begin
          lfsr_d  = chain_s[W];
          par_d   = chunk;
          valid_d = 1'b1;
          wrap_d  = |hit;
          cnt_d   = (|hit) ? steps_past : cnt_q + N'(W);
          fsm_d   = S_RUN;
`ifdef MSEQ_ZERO_GUARD_EN
          if (chain_s[W] == '0) fsm_d = S_RECOVER;
`endif
        end
      end
`ifdef MSEQ_ZERO_GUARD_EN
      // Single recovery cycle: loads and enables are both ignored here.
      S_RECOVER: begin
        lfsr_d = DEF_SEED;
        seed_d = DEF_SEED;
        cnt_d  = '0;
        fsm_d  = S_RUN;
      end
`endif
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      fsm_q   <= S_IDLE;
      lfsr_q  <= DEF_SEED;
      taps_q  <= DEF_TAPS;
      seed_q  <= DEF_SEED;
      par_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      taps_q  <= taps_d;
      seed_q  <= seed_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_sig        = par_q[W-1];
  assign m_par_sig    = par_q;
  assign valid_sig    = valid_q;
  assign wrap_sig     = wrap_q;
  assign step_cnt_sig = cnt_q;

endmodule

// File: tb/tb_mseq_gen.sv
// tb/tb_mseq_gen.sv - self-checking bench for mseq_gen (N=16/W=1, N=4/W=1, N=4/W=3)
module tb_mseq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        x_en, x_load, x_m, x_valid, x_wrap;
  logic [15:0] x_seed, x_taps, x_cnt;
  logic [0:0]  x_par;

  logic        s_en, s_load, s_m, s_valid, s_wrap;
  logic [3:0]  s_seed, s_taps, s_cnt;
  logic [0:0]  s_par;

  logic        p_en, p_load, p_m, p_valid, p_wrap;
  logic [3:0]  p_seed, p_taps, p_cnt;
  logic [2:0]  p_par;

  int total = 0;
  int bad   = 0;

  mseq_gen #(.N(16), .W(1), .DEF_TAPS(16'hB400), .DEF_SEED(16'h0001)) u_x16 (
    .clk_sig(clk), .rst_sig(rst_n), .en_sig(x_en), .load_sig(x_load),
    .seed_sig(x_seed), .taps_sig(x_taps), .m_sig(x_m), .m_par_sig(x_par),
    .valid_sig(x_valid), .wrap_sig(x_wrap), .step_cnt_sig(x_cnt));

  mseq_gen #(.N(4), .W(1), .DEF_TAPS(4'hC), .DEF_SEED(4'h1)) u_s4 (
    .clk_sig(clk), .rst_sig(rst_n), .en_sig(s_en), .load_sig(s_load),
    .seed_sig(s_seed), .taps_sig(s_taps), .m_sig(s_m), .m_par_sig(s_par),
    .valid_sig(s_valid), .wrap_sig(s_wrap), .step_cnt_sig(s_cnt));

  mseq_gen #(.N(4), .W(3), .DEF_TAPS(4'hC), .DEF_SEED(4'h1)) u_p4 (
    .clk_sig(clk), .rst_sig(rst_n), .en_sig(p_en), .load_sig(p_load),
    .seed_sig(p_seed), .taps_sig(p_taps), .m_sig(p_m), .m_par_sig(p_par),
    .valid_sig(p_valid), .wrap_sig(p_wrap), .step_cnt_sig(p_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x_en = 0; x_load = 0; x_seed = '0; x_taps = '0;
    s_en = 0; s_load = 0; s_seed = '0; s_taps = '0;
    p_en = 0; p_load = 0; p_seed = '0; p_taps = '0;
    tick(); tick();
    total++;
    if ({x_m, x_par, x_valid, x_wrap, x_cnt} !== 20'h0) begin
      bad++; $display("FAIL reset_x16: got %h want 0", {x_m, x_par, x_valid, x_wrap, x_cnt});
    end
    total++;
    if ({s_m, s_par, s_valid, s_wrap, s_cnt} !== 8'h0) begin
      bad++; $display("FAIL reset_s4: got %h want 0", {s_m, s_par, s_valid, s_wrap, s_cnt});
    end
    total++;
    if ({p_m, p_par, p_valid, p_wrap, p_cnt} !== 10'h0) begin
      bad++; $display("FAIL reset_p4: got %h want 0", {p_m, p_par, p_valid, p_wrap, p_cnt});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_n4_serial();
    logic [14:0] ref_bits;
    int          ph;
    ref_bits = 15'b000100110101111;
    s_load = 1; s_seed = 4'h1; s_taps = 4'hC;
    tick();
    s_load = 0;
    total++;
    if ({s_valid, s_cnt} !== 5'h0) begin
      bad++; $display("FAIL n4_serial_load: got %h want 0", {s_valid, s_cnt});
    end
    s_en = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      ph = i % 15;
      total++;
      if ({s_m, s_valid, s_wrap, s_cnt} !== {ref_bits[14-ph], 1'b1, ph == 14, 4'((i + 1) % 15)}) begin
        bad++;
        $display("FAIL n4_serial[%0d]: got m=%b v=%b w=%b c=%0d want m=%b v=1 w=%b c=%0d",
                 i, s_m, s_valid, s_wrap, s_cnt, ref_bits[14-ph], ph == 14, (i + 1) % 15);
      end
    end
    s_en = 0;
    tick();
    total++;
    if ({s_valid, s_wrap} !== 2'b00) begin
      bad++; $display("FAIL n4_serial_hold: got %b want 00", {s_valid, s_wrap});
    end
  endtask

  task automatic test_n4_chunk();
    logic [2:0] tbl [5];
    tbl = '{3'b000, 3'b100, 3'b110, 3'b101, 3'b111};
    p_load = 1; p_seed = 4'h1; p_taps = 4'hC;
    tick();
    p_load = 0;
    p_en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({p_m, p_par, p_valid, p_wrap, p_cnt} !== {tbl[i][2], tbl[i], 1'b1, i == 4, 4'((3 * (i + 1)) % 15)}) begin
        bad++;
        $display("FAIL n4_chunk[%0d]: got par=%b w=%b c=%0d want par=%b w=%b c=%0d",
                 i, p_par, p_wrap, p_cnt, tbl[i], i == 4, (3 * (i + 1)) % 15);
      end
    end
    p_en = 0;
    tick();
  endtask

  task automatic test_n16_period();
    int n   = 0;
    bit got = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    x_en  = 1;
    for (int c = 0; c < 70000 && !got; c++) begin
      tick();
      if (x_valid) n++;
      if (x_wrap) got = 1;
    end
    x_en = 0;
    total++;
    if (!got) begin
      bad++; $display("FAIL n16_period_timeout: got no wrap want wrap within 70000 cycles");
    end
    total++;
    if (n !== 65535) begin
      bad++; $display("FAIL n16_period_len: got %0d want 65535", n);
    end
    total++;
    if (x_cnt !== 16'h0) begin
      bad++; $display("FAIL n16_period_cnt: got %0d want 0", x_cnt);
    end
    tick();
  endtask

  task automatic test_load_priority();
    logic [15:0] seed;
    for (int r = 0; r < 4; r++) begin
      seed   = 16'($urandom_range(1, 65535));
      x_load = 1; x_en = 1; x_seed = seed; x_taps = 16'hB400;
      tick();
      x_load = 0;
      total++;
      if ({x_valid, x_cnt} !== 17'h0) begin
        bad++; $display("FAIL load_prio_noadv[%0d]: got v=%b c=%0d want v=0 c=0", r, x_valid, x_cnt);
      end
      tick();
      total++;
      if ({x_valid, x_m, x_wrap, x_cnt} !== {1'b1, seed[15], 1'b0, 16'd1}) begin
        bad++;
        $display("FAIL load_prio_first[%0d]: got v=%b m=%b w=%b c=%0d want v=1 m=%b w=0 c=1",
                 r, x_valid, x_m, x_wrap, x_cnt, seed[15]);
      end
      x_en = 0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_zero_seed();
    s_load = 1; s_seed = 4'h0; s_taps = 4'hC;
    tick();
    s_load = 0;
    s_en   = 1;
`ifdef MSEQ_ZERO_GUARD_EN
    begin
      logic [14:0] ref_bits;
      ref_bits = 15'b000100110101111;
      tick();
      total++;
      if ({s_valid, s_wrap, s_cnt} !== 6'h0) begin
        bad++; $display("FAIL zero_recover: got v=%b w=%b c=%0d want 0", s_valid, s_wrap, s_cnt);
      end
      for (int i = 0; i < 6; i++) begin
        tick();
        total++;
        if ({s_m, s_valid, s_wrap, s_cnt} !== {ref_bits[14-i], 1'b1, 1'b0, 4'(i + 1)}) begin
          bad++;
          $display("FAIL zero_restart[%0d]: got m=%b v=%b w=%b c=%0d want m=%b v=1 w=0 c=%0d",
                   i, s_m, s_valid, s_wrap, s_cnt, ref_bits[14-i], i + 1);
        end
      end
    end
`else
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if ({s_m, s_valid, s_wrap, s_cnt} !== 7'b0110000) begin
        bad++;
        $display("FAIL zero_stuck[%0d]: got m=%b v=%b w=%b c=%0d want m=0 v=1 w=1 c=0",
                 i, s_m, s_valid, s_wrap, s_cnt);
      end
    end
`endif
    s_en = 0;
    tick();
  endtask

  task automatic test_async_reset();
    logic [14:0] ref_bits;
    ref_bits = 15'b000100110101111;
    s_load = 1; s_seed = 4'hA; s_taps = 4'hC;
    tick();
    s_load = 0;
    s_en   = 1;
    repeat (4) tick();
    #2;
    rst_n = 0;
    s_en  = 0;
    #1;
    total++;
    if ({s_m, s_par, s_valid, s_wrap, s_cnt} !== 8'h0) begin
      bad++; $display("FAIL async_reset: got %h want 0", {s_m, s_par, s_valid, s_wrap, s_cnt});
    end
    @(negedge clk);
    rst_n = 1;
    s_en  = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({s_m, s_valid, s_cnt} !== {ref_bits[14-i], 1'b1, 4'(i + 1)}) begin
        bad++;
        $display("FAIL async_restart[%0d]: got m=%b v=%b c=%0d want m=%b v=1 c=%0d",
                 i, s_m, s_valid, s_cnt, ref_bits[14-i], i + 1);
      end
    end
    s_en = 0;
    tick();
  endtask

  task automatic test_random();
    int unsigned ms, mt, mq, mc, seed, taps;
    logic [2:0]  exp_par;
    logic        exp_v, exp_w, ld, en;
    ms = 1; mt = 12; mq = 1; mc = 0;
    exp_par = 3'b000;
    for (int c = 0; c < 300; c++) begin
      ld   = (c == 0) || ($urandom_range(0, 9) == 0);
      seed = $urandom_range(1, 15);
      taps = 8 | $urandom_range(0, 7);
      en   = ld ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) < 7);
      p_load = ld; p_en = en; p_seed = 4'(seed); p_taps = 4'(taps);
      tick();
      if (ld) begin
        ms = seed; mt = taps; mq = seed; mc = 0;
        exp_v = 0; exp_w = 0;
      end else if (en) begin
        exp_v = 1; exp_w = 0;
        for (int k = 0; k < 3; k++) begin
          exp_par[2-k] = 1'((ms >> 3) & 1);
          ms = ((ms << 1) | ($countones(ms & mt) & 1)) & 15;
          mc = (mc + 1) % 16;
          if (ms == mq) begin
            exp_w = 1;
            mc    = 0;
          end
        end
      end else begin
        exp_v = 0; exp_w = 0;
      end
      total++;
      if ({p_m, p_par, p_valid, p_wrap, p_cnt} !== {exp_par[2], exp_par, exp_v, exp_w, 4'(mc)}) begin
        bad++;
        $display("FAIL random[%0d]: got par=%b v=%b w=%b c=%0d want par=%b v=%b w=%b c=%0d",
                 c, p_par, p_valid, p_wrap, p_cnt, exp_par, exp_v, exp_w, mc);
      end
    end
    p_load = 0; p_en = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_n4_serial();
    test_n4_chunk();
    test_n16_period();
    test_load_priority();
    test_zero_seed();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mseq_gen.md
Name: mseq_gen

Overview:
Parametrised Fibonacci m-sequence (PN) generator.
- Generalises the fixed 16-stage serial generator with:
  - configurable degree N
  - runtime-programmable tap polynomial
  - seed load
  - W bits per clock
  - period-boundary flag and step counter
- Feeds BPSK spreading, scrambling and bench reference paths.

Parameters:
- N, 16, LFSR degree (2..32).
- W, 1, output bits produced per enabled cycle (1..N).
- DEF_TAPS, 16'hB400, tap mask after reset (x^16+x^14+x^13+x^11+1); bit i set means state bit i feeds the XOR.
- DEF_SEED, 1, state after reset; must be nonzero.

Ports:
- clk_sig  in  1  clock, rising edge.
- rst_sig  in  1  asynchronous active-low reset.
- en_sig  in  1  advance W steps this cycle.
- load_sig  in  1  load seed_sig and taps_sig.
- seed_sig  in  N  seed value, sampled on load.
- taps_sig  in  N  tap mask, sampled on load.
- m_sig  out  1  serial bit: first bit of the current chunk.
- m_par_sig  out  W  chunk bits; bit W-1 is the oldest.
- valid_sig  out  1  m_sig and m_par_sig updated this cycle.
- wrap_sig  out  1  chunk contained a return to the loaded seed.
- step_cnt_sig  out  N  steps since last load or wrap.

Behaviour:
- Reset (rst_sig low, async):
  - state=DEF_SEED, taps=DEF_TAPS, seed_q=DEF_SEED
  - FSM=S_IDLE
  - m_sig, m_par_sig, valid_sig, wrap_sig, step_cnt_sig all 0
- One step:
  - out = s[N-1]
  - fb = ^(s & taps)
  - s <= {s[N-2:0], fb}
- Enabled cycle: W chained steps.
  - m_par_sig[W-1-k] = out of step k.
  - m_sig = m_par_sig[W-1].
  - Outputs are registered and appear 1 cycle after en_sig; valid_sig pulses 1 cycle.
- FSM states:
  - S_IDLE: outputs hold and valid_sig=0. load_sig goes to S_RUN; en_sig goes to S_RUN and the same cycle advances with the current state.
  - S_RUN: en_sig advances; en_sig low holds everything and drops valid_sig/wrap_sig to 0.
  - S_RECOVER: exists only with the macro (see Optional Feature).
- Load:
  - load_sig has priority over en_sig in the same cycle.
  - seed, taps and seed_q are latched; no step is taken.
  - step_cnt clears to 0; valid_sig=0.
  - New state is visible the next cycle; the first bit of the new sequence comes out on the cycle after the first en_sig.
- Wrap:
  - Raised if any of the W intermediate next-states equals seed_q.
  - wrap_sig pulses with valid_sig.
  - step_cnt_sig takes the number of steps past the matching state; otherwise step_cnt += W, modulo 2^N.
- Load while mid-chunk is not possible: a chunk completes within one cycle.
- Reset mid-run returns to the reset values immediately.
- Non-primitive taps are allowed: wrap still pulses at that shorter cycle.

Optional Feature:
- Macro: MSEQ_ZERO_GUARD_EN.
- With it:
  - An all-zero state after load or step enters S_RECOVER for 1 cycle.
  - That cycle: state <= DEF_SEED, seed_q <= DEF_SEED, valid_sig=0, wrap_sig=0, step_cnt=0.
  - Then returns to S_RUN.
  - en_sig during S_RECOVER is ignored.
- Without it: an all-zero seed is accepted and the generator outputs constant 0 forever; wrap_sig pulses on every enabled cycle.

Decomposition:
- Package mseq_pkg holds:
  - FSM state encoding: S_IDLE, S_RUN, S_RECOVER.
  - Default tap constants for N = 4, 7, 9, 11, 15, 16, 23, 31.
  - Function next_state(s, taps).
- Sub-module mseq_step: combinational single step (s, taps -> s_next, out). It is instantiated W times in a chain.

Test Plan:
1. N=4, W=1: load seed=4'b0001, taps=4'b1100; hold en high.
   -> m_sig = 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1, then repeats.
   -> wrap_sig pulses on the 15th valid bit; step_cnt_sig restarts at 0.
2. Same load with W=3: 5 enabled cycles.
   -> m_par_sig = 3'b000, 3'b100, 3'b110, 3'b101, 3'b111.
   -> wrap_sig set only on the 5th.
3. N=16 defaults, en high from release of reset.
   -> first wrap_sig after exactly 65535 valid cycles.
4. load_sig and en_sig asserted together.
   -> no valid_sig that cycle; next valid bit is the MSB of the new seed.
5. Seed 0 loaded:
   - With MSEQ_ZERO_GUARD_EN: 1 recovery cycle, valid_sig=0, then a sequence from DEF_SEED.
   - Without it: m_sig stays 0 and wrap_sig stays high while en is high.
6. rst_sig pulled low mid-run, asynchronously between edges.
   -> all outputs 0 immediately.
   -> after release and en, the sequence restarts from DEF_SEED with DEF_TAPS.
